uart_tx_stream: RTL

Parametrised, buffered UART transmitter, the next-generation TX path of the APB-UART. A DATA_W-wide transmit FIFO decouples the register block from the serial line. The block serialises 5..DATA_W data bits with none, even, odd, mark or space parity, 1 or 2 stop bits, CTS flow control and line-break generation. One bit period equals the interval between `tx_tick` pulses from the baud generator.

---
 rtl/uart_tx_stream.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_stream.sv
// Buffered UART transmitter: FIFO-fed serialiser with configurable data width, parity,
// stop bits, CTS flow control and line-break generation. One bit period per tx_tick.
module uart_tx_stream #(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tx_tick,
    input  logic                          wr_valid,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    input  logic                          flush,
    input  logic [3:0]                    data_bits,
    input  logic [2:0]                    parity_mode,
    input  logic                          stop2,
    input  logic                          break_req,
    input  logic                          cts_n,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] MAX_BITS = 4'(DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    // ---------------- transmit FIFO ----------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    assign fifo_level = wr_ptr - rd_ptr;
    assign wr_ready   = (fifo_level != (AW+1)'(FIFO_DEPTH));
    assign push       = wr_valid && wr_ready && !flush;
    assign head       = mem[rd_ptr[AW-1:0]];

    // NOTE: the storage array has no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- frame configuration of the head entry ----------------
    logic [3:0] n_clamp;
    logic       par_en;
    logic       par_bit;
    logic       data_xor;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        n_clamp = data_bits;
        if (data_bits < 4'd5)          n_clamp = 4'd5;
        else if (data_bits > MAX_BITS) n_clamp = MAX_BITS;

        data_xor = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (4'(i) < n_clamp) data_xor = data_xor ^ head[i];
        end

        par_en  = (parity_mode >= 3'd1) && (parity_mode <= 3'd4);
        par_bit = 1'b0;
        case (parity_mode)
            3'd1:    par_bit = data_xor;
            3'd2:    par_bit = ~data_xor;
            3'd3:    par_bit = 1'b1;
            default: par_bit = 1'b0;
        endcase
    end

    // ---------------- serialiser FSM ----------------
    state_t            state;
    logic [DATA_W-1:0] shift;
    logic [3:0]        bit_cnt;
    logic [3:0]        n_q;
    logic              par_en_q;
    logic              par_bit_q;
    logic              stop2_q;
    logic              stop_cnt;
    logic              launch_ok;
    logic              last_stop;

    assign launch_ok = (fifo_level != '0) && !cts_n && !break_req;
    assign last_stop = (stop_cnt == stop2_q);
    // A frame launches from IDLE or straight out of the final stop bit (back-to-back).
    assign pop       = tx_tick && launch_ok &&
                       ((state == IDLE) || ((state == STOP) && last_stop));
    assign tx_busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            frame_done <= 1'b0;
            shift      <= '0;
            bit_cnt    <= '0;
            n_q        <= 4'd5;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (pop) begin
                state     <= START;
                tx        <= 1'b0;
                shift     <= head;
                bit_cnt   <= '0;
                n_q       <= n_clamp;
                par_en_q  <= par_en;
                par_bit_q <= par_bit;
                stop2_q   <= stop2;
            end
            if (tx_tick) begin
                case (state)
                    IDLE: begin
                        if (break_req) begin
                            state <= BREAK;
                            tx    <= 1'b0;
                        end
                    end
                    START: begin
                        state <= DATA;
                        tx    <= shift[0];
                        shift <= shift >> 1;
                    end
                    DATA: begin
                        if (bit_cnt == n_q - 4'd1) begin
                            stop_cnt <= 1'b0;
                            if (par_en_q) begin
                                state <= PARITY;
                                tx    <= par_bit_q;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    PARITY: begin
                        state    <= STOP;
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                    STOP: begin
                        if (last_stop) begin
                            frame_done <= 1'b1;
                            if (!pop) begin
                                state <= IDLE;
                                tx    <= 1'b1;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                    BREAK: begin
                        if (!break_req) begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
